// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles the UART receive byte stream into SYNC, ADDR, DATA, CHK command
//   frames. It validates the checksum, the address range and the inter-byte
//   timing, then presents {addr, data} on a valid/ready handshake. Errors are
//   reported as a one-cycle pulse with a cause code and a saturating count.
//
// Ports
//   i_Clock       system clock
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_DV       one-cycle byte-valid strobe from the UART receiver
//   i_Rx_Byte     received byte, sampled when i_Rx_DV=1
//   o_Cmd_Valid   command available, held until accepted
//   o_Cmd_Addr    command address, stable while o_Cmd_Valid=1
//   o_Cmd_Data    command data, stable while o_Cmd_Valid=1
//   i_Cmd_Ready   consumer accepts the command at an edge with o_Cmd_Valid=1
//   o_Err_Pulse   one-cycle error strobe
//   o_Err_Code    00 checksum, 01 address, 10 timeout, 11 overrun (held)
//   o_Err_Count   saturating error count
//   o_Busy        high whenever the parser is not idle
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         NUM_DEVICES  = 16,
    parameter int         TIMEOUT_CLKS = 52080
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Cmd_Valid,
    output logic [7:0] o_Cmd_Addr,
    output logic [7:0] o_Cmd_Data,
    input  logic       i_Cmd_Ready,
    output logic       o_Err_Pulse,
    output logic [1:0] o_Err_Code,
    output logic [7:0] o_Err_Count,
    output logic       o_Busy
);

    localparam int            CW         = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CLKS - 1);
    // One extra bit so NUM_DEVICES=256 still compares correctly.
    localparam logic [8:0]    ADDR_LIMIT = 9'(NUM_DEVICES);

    localparam logic [1:0] ERR_CHECKSUM = 2'b00;
    localparam logic [1:0] ERR_ADDRESS  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    checksum;
    logic [CW-1:0] timer;
    logic          timed_state;
    logic          timer_expired;
    logic          err_set;
    logic [1:0]    err_code_next;
    logic          cmd_load;
    logic          cmd_clear;
    logic          rx_sync;

    // Carry is discarded: the checksum is the 8-bit sum.
    assign checksum    = addr_q + data_q;
    assign rx_sync     = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
    assign timed_state = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timer_expired = (timer == TIMER_LAST) && !i_Rx_DV;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        err_set       = 1'b0;
        err_code_next = o_Err_Code;
        cmd_load      = 1'b0;
        cmd_clear     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_sync) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                if (i_Rx_DV) begin
                    state_next = (state == S_ADDR) ? S_DATA : S_CHK;
                end else if (timer_expired) begin
                    state_next    = S_IDLE;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != checksum) begin
                        state_next    = S_IDLE;
                        err_set       = 1'b1;
                        err_code_next = ERR_CHECKSUM;
                    end else if ({1'b0, addr_q} >= ADDR_LIMIT) begin
                        state_next    = S_IDLE;
                        err_set       = 1'b1;
                        err_code_next = ERR_ADDRESS;
                    end else begin
                        state_next = S_HOLD;
                        cmd_load   = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next    = S_IDLE;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_HOLD: begin
                // On the accepting edge, a new byte is treated as if it
                // arrived in S_IDLE, so a SYNC byte starts the next frame.
                if (i_Cmd_Ready) begin
                    cmd_clear  = 1'b1;
                    state_next = rx_sync ? S_ADDR : S_IDLE;
                end else if (i_Rx_DV) begin
                    err_set       = 1'b1;
                    err_code_next = ERR_OVERRUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The timer restarts on every byte and on every state change, so it
    // measures idle time since the last event within the frame.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            timer <= '0;
        end else if (timed_state && !i_Rx_DV && (state_next == state)) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (i_Rx_DV) begin
            if (state == S_ADDR) begin
                addr_q <= i_Rx_Byte;
            end
            if (state == S_DATA) begin
                data_q <= i_Rx_Byte;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Cmd_Valid <= 1'b0;
            o_Cmd_Addr  <= '0;
            o_Cmd_Data  <= '0;
        end else if (cmd_load) begin
            o_Cmd_Valid <= 1'b1;
            o_Cmd_Addr  <= addr_q;
            o_Cmd_Data  <= data_q;
        end else if (cmd_clear) begin
            o_Cmd_Valid <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Err_Pulse <= 1'b0;
            o_Err_Code  <= '0;
            o_Err_Count <= '0;
            o_Busy      <= 1'b0;
        end else begin
            o_Err_Pulse <= err_set;
            o_Busy      <= (state_next != S_IDLE);
            if (err_set) begin
                o_Err_Code <= err_code_next;
                if (o_Err_Count != 8'hFF) begin
                    o_Err_Count <= o_Err_Count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed bench for uart_cmd_parser with TIMEOUT_CLKS shortened to 100.
//   Inputs change on the falling edge and outputs are checked on the
//   following falling edge, i.e. half a clock after the rising edge that
//   produced them.
module tb_uart_cmd_parser;

    logic       clock;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_cmd_parser #(
        .SYNC_BYTE   (8'hA5),
        .NUM_DEVICES (16),
        .TIMEOUT_CLKS(100)
    ) dut (
        .i_Clock    (clock),
        .i_Rst_n    (rst_n),
        .i_Rx_DV    (rx_dv),
        .i_Rx_Byte  (rx_byte),
        .o_Cmd_Valid(cmd_valid),
        .o_Cmd_Addr (cmd_addr),
        .o_Cmd_Data (cmd_data),
        .i_Cmd_Ready(cmd_ready),
        .o_Err_Pulse(err_pulse),
        .o_Err_Code (err_code),
        .o_Err_Count(err_count),
        .o_Busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clock);
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
        #12;
        checks++;
        if ({cmd_valid, cmd_addr, cmd_data, err_pulse, err_code, err_count, busy} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {cmd_valid, cmd_addr, cmd_data, err_pulse, err_code, err_count, busy});
        end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        cmd_ready = 1'b1;
        send_byte(8'h55);
        checks++;
        if (busy !== 1'b0 || err_pulse !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_garbage: got busy=%0b err=%0b want 0/0", busy, err_pulse);
        end
        send_frame(8'h03, 8'h7E, 8'h81);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h03 || cmd_data !== 8'h7E) begin
            errors++;
            $display("[TB] FAIL nominal_cmd: got v=%0b a=%h d=%h want 1/03/7e", cmd_valid, cmd_addr, cmd_data);
        end
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'd0) begin
            errors++; $display("[TB] FAIL nominal_noerr: got p=%0b cnt=%0d want 0/0", err_pulse, err_count);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL nominal_release: got v=%0b busy=%0b want 0/0", cmd_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int held;
        held = 0;
        cmd_ready = 1'b0;
        send_frame(8'h02, 8'h10, 8'h12);
        for (int i = 0; i < 21; i++) begin
            if (cmd_valid === 1'b1 && cmd_addr === 8'h02 && cmd_data === 8'h10) held++;
            if (i < 20) tick();
        end
        checks++;
        if (held !== 21) begin
            errors++; $display("[TB] FAIL backpressure_hold: got %0d cycles want 21", held);
        end
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL backpressure_clear: got v=%0b busy=%0b want 0/0", cmd_valid, busy);
        end
    endtask

    task automatic test_errors();
        send_frame(8'h03, 8'h7E, 8'h80);
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 2'b00 || err_count !== 8'd1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL checksum_err: got p=%0b c=%0d n=%0d v=%0b want 1/0/1/0",
                     err_pulse, err_code, err_count, cmd_valid);
        end
        tick();
        checks++;
        if (err_pulse !== 1'b0) begin
            errors++; $display("[TB] FAIL pulse_width: got %0b want 0", err_pulse);
        end
        send_frame(8'h20, 8'h01, 8'h21);
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 2'b01 || err_count !== 8'd2 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL address_err: got p=%0b c=%0d n=%0d v=%0b want 1/1/2/0",
                     err_pulse, err_code, err_count, cmd_valid);
        end
        tick();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h05);
        repeat (99) tick();
        checks++;
        if (err_pulse !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_early: got p=%0b busy=%0b want 0/1", err_pulse, busy);
        end
        tick();
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 2'b10 || err_count !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_err: got p=%0b c=%0d n=%0d busy=%0b want 1/2/3/0",
                     err_pulse, err_code, err_count, busy);
        end
        tick();
        send_byte(8'hA5);
        send_byte(8'h05);
        repeat (99) tick();
        send_byte(8'h07);
        checks++;
        if (err_pulse !== 1'b0 || busy !== 1'b1 || err_count !== 8'd3) begin
            errors++;
            $display("[TB] FAIL expiry_byte_wins: got p=%0b busy=%0b n=%0d want 0/1/3", err_pulse, busy, err_count);
        end
        send_byte(8'h0C);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h05 || cmd_data !== 8'h07) begin
            errors++;
            $display("[TB] FAIL expiry_cmd: got v=%0b a=%h d=%h want 1/05/07", cmd_valid, cmd_addr, cmd_data);
        end
        tick();
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        send_frame(8'h09, 8'h01, 8'h0A);
        send_byte(8'h55);
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 2'b11 || err_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL overrun_err: got p=%0b c=%0d n=%0d want 1/3/4", err_pulse, err_code, err_count);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h09 || cmd_data !== 8'h01) begin
            errors++;
            $display("[TB] FAIL overrun_hold: got v=%0b a=%h d=%h want 1/09/01", cmd_valid, cmd_addr, cmd_data);
        end
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || err_pulse !== 1'b0 || err_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL back_to_back_sync: got v=%0b busy=%0b p=%0b n=%0d want 0/1/0/4",
                     cmd_valid, busy, err_pulse, err_count);
        end
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h09);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h04 || cmd_data !== 8'h05) begin
            errors++;
            $display("[TB] FAIL back_to_back_cmd: got v=%0b a=%h d=%h want 1/04/05", cmd_valid, cmd_addr, cmd_data);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) send_frame(8'h00, 8'h00, 8'h01);
        checks++;
        if (err_count !== 8'd255 || err_pulse !== 1'b1 || err_code !== 2'b00) begin
            errors++;
            $display("[TB] FAIL saturation: got n=%0d p=%0b c=%0d want 255/1/0", err_count, err_pulse, err_code);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5);
        send_byte(8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_addr, cmd_data, err_pulse, err_code, err_count, busy} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h want 0",
                     {cmd_valid, cmd_addr, cmd_data, err_pulse, err_code, err_count, busy});
        end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        send_frame(8'h01, 8'h02, 8'h03);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 8'h01 || cmd_data !== 8'h02 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_cmd: got v=%0b a=%h d=%h n=%0d want 1/01/02/0",
                     cmd_valid, cmd_addr, cmd_data, err_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_errors();
        test_timeout();
        test_overrun();
        test_saturation();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
